vga_tile_renderer: RTL and testbench
====================================

// Module: vga_tile_renderer
// PURPOSE
//  Parametrised successor to the snake board renderer. Generates VGA timing for any mode
//  and draws a tiled game board from an external cell RAM, with configurable read latency.
//  Draws a border around the board that flashes on game over.
//  Sits between the game-state RAM (read port) and the VGA DAC pins.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch (clocks)
//  H_SYNC      96   horizontal sync width
//  H_BP        48   horizontal back porch
//  V_ACTIVE    400  visible lines
//  V_FP        12   vertical front porch (lines)
//  V_SYNC      2    vertical sync width
//  V_BP        35   vertical back porch
//  HS_POL      0    hs asserted level (0 = active-low)
//  VS_POL      1    vs asserted level
//  TILE_LOG2   4    tile edge = 2**TILE_LOG2 pixels
//  BOARD_W     32   board width in tiles; ram_x width = clog2(BOARD_W)
//  BOARD_H     16   board height in tiles; ram_y width = clog2(BOARD_H)
//  BOARD_X0    64   board left edge, pixel x
//  BOARD_Y0    48   board top edge, pixel y
//  BORDER      16   border thickness in pixels, drawn outside the board
//  CELL_W      4    ram_out width
//  RAM_LAT     1    cycles from ram_x/ram_y change to valid ram_out (1..3)
//  FLASH_LOG2  5    border toggles every 2**FLASH_LOG2 frames while game_over
// PORTS
//  clk          in   1        pixel clock
//  rst_n        in   1        asynchronous reset, active low
//  hs           out  1        horizontal sync
//  vs           out  1        vertical sync
//  r            out  3        red
//  g            out  3        green
//  b            out  2        blue
//  ram_x        out  XW       cell column address
//  ram_y        out  YW       cell row address
//  ram_out      in   CELL_W   cell content, valid RAM_LAT cycles after address
//  game_over    in   1        level input; sampled once per frame at frame_start
//  frame_start  out  1        1-cycle pulse when h_cnt==0 && v_cnt==0
// BEHAVIOUR
//  - Timing: clock and reset are decided as above (one clock clk; rst_n async, active-low).
//  - Reset: h_cnt=v_cnt=0; hs=~HS_POL; vs=~VS_POL; {r,g,b}=0; ram_x=ram_y=0;
//    frame_start=0; flash_cnt=0; go_lat=0.
//  - h_cnt runs 0..H_TOTAL-1, then wraps to 0. H_TOTAL = sum of the H_* parameters.
//  - v_cnt increments on the h wrap and runs 0..V_TOTAL-1. No off-by-one lines.
//  - Line order is active, FP, sync, BP. Sync is asserted for [ACTIVE+FP, ACTIVE+FP+SYNC).
//  - Pipeline with L = RAM_LAT+2:
//    - Stage 0: counters.
//    - Stage 1: ram_x/ram_y and region flags registered.
//    - Stage 1+RAM_LAT: ram_out valid.
//    - Stage L: rgb registered.
//    - hs, vs and visible are delayed by L so they stay pixel-aligned with rgb.
//  - Board: x in [X0, X0+BOARD_W<<T), y in [Y0, Y0+BOARD_H<<T).
//    - Address: ram_x = (x-X0)>>T, ram_y = (y-Y0)>>T.
//    - Outside the board, ram_x/ram_y hold their last value.
//  - Dot: inside the board with tile-local x and y both in [2, 2**T-2]; otherwise gap.
//  - Border: within BORDER pixels outside the board edges, corners included.
//  - Colour priority (8'bRRRGGGBB):
//    - not visible -> 0
//    - border -> 8'b01001010; if go_lat && flash_phase -> 8'b11100000
//    - dot && ram_out all-ones -> 8'b10010000
//    - dot && ram_out != 0 -> 8'hFF
//    - else -> 8'b00100101
//  - Flashing: flash_cnt (FLASH_LOG2+1 bits) increments at each frame_start while go_lat=1.
//    - flash_phase = flash_cnt MSB.
//    - go_lat is updated only at frame_start, so there is no mid-frame tearing.
//    - When go_lat falls, flash_cnt clears.
//  - Reset asserted mid-frame: outputs return to reset values immediately.
//    Timing restarts at 0,0 after release.
// STRUCTURE
//  - vga_pkg.vh (shared): colour constants, clog2 function.
//  - Sub-module vga_timing: counters, raw sync, visible, frame_start.
//    Reused by future video blocks.
//  - This module: address generation, delay lines of length L, colour mux, flash logic.
// TESTING
//  1. Defaults, 2 frames: hs low 96 clks per 800; vs high lines 412-413; 449 lines/frame;
//     frame_start period 359200.
//  2. RAM model latency RAM_LAT=1, then 3; cell(0,0)=4'hF:
//     pixel (66,50) = 8'b10010000 exactly L clks after counters reach it.
//  3. cell(31,15)=4'h3: pixel (573,299) = 8'hFF; pixel (575,299) (gap) = 8'b00100101;
//     pixel (640+) = 0.
//  4. game_over=1 raised mid-frame: border stays 8'b01001010 until the next frame_start,
//     then toggles red/base every 32 frames.
//  5. rst_n pulsed low at h=300, v=200: hs=1, vs=0, rgb=0 at once (async);
//     frame_start 359200 clks after release.
//  6. Non-default mode (H_ACTIVE=800, TILE_LOG2=5, BOARD_W=16): sync widths and
//     tile addressing scale correctly.

Source files
------------

// File: rtl/vga_tile_renderer_pkg.sv
// Shared video constants: palette entries, per-pixel region flags, and a clog2 helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_tile_renderer_pkg;

    // Palette, 8'bRRRGGGBB
    localparam logic [7:0] RGB_OFF       = 8'h00;
    localparam logic [7:0] RGB_BORDER    = 8'b010_010_10;
    localparam logic [7:0] RGB_BORDER_GO = 8'b111_000_00;
    localparam logic [7:0] RGB_CELL_FULL = 8'b100_100_00;
    localparam logic [7:0] RGB_CELL      = 8'hFF;
    localparam logic [7:0] RGB_BG        = 8'b001_001_01;

    // Region flags for one pixel, carried down the pipeline alongside the RAM read
    typedef struct packed {
        logic visible;
        logic border;
        logic dot;
    } meta_t;

    // Ceiling log2, never less than 1 so that derived port widths stay legal
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_tile_renderer_timing.sv
// Raster timing: h/v counters, raw sync levels, visible flag and a frame_start pulse.
// Latency: hs_raw/vs_raw/visible are combinational from the counters; frame_start is high while counters are 0,0.
// Backpressure: none, free-running at the pixel clock.
module vga_tile_renderer_timing
    import vga_tile_renderer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 400,
    parameter int V_FP     = 12,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 35,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b1,
    parameter int HW       = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          hs_raw,
    output logic          vs_raw,
    output logic          visible,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;

    // Next raster position: h wraps at end of line, v advances on that wrap
    always_comb begin
        h_nxt = h_cnt + 1'b1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    // Counter state; frame_start is registered from the next position so it
    // stays low in the first cycle after reset even though counters sit at 0,0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    assign hs_raw  = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
    assign vs_raw  = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
    assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);

endmodule

// File: rtl/vga_tile_renderer.sv
// Tiled board renderer: raster timing, cell RAM addressing, border/dot colour mux with game-over flash.
// Latency: RAM_LAT+2 clocks from counter position to rgb/hs/vs, all pixel-aligned.
// Backpressure: none; the cell RAM must return data exactly RAM_LAT clocks after the address.
module vga_tile_renderer
    import vga_tile_renderer_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 400,
    parameter int V_FP       = 12,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 35,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b1,
    parameter int TILE_LOG2  = 4,
    parameter int BOARD_W    = 32,
    parameter int BOARD_H    = 16,
    parameter int BOARD_X0   = 64,
    parameter int BOARD_Y0   = 48,
    parameter int BORDER     = 16,
    parameter int CELL_W     = 4,
    parameter int RAM_LAT    = 1,
    parameter int FLASH_LOG2 = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        hs,
    output logic                        vs,
    output logic [2:0]                  r,
    output logic [2:0]                  g,
    output logic [1:0]                  b,
    output logic [clog2(BOARD_W)-1:0]   ram_x,
    output logic [clog2(BOARD_H)-1:0]   ram_y,
    input  logic [CELL_W-1:0]           ram_out,
    input  logic                        game_over,
    output logic                        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = clog2(H_TOTAL);
    localparam int VW      = clog2(V_TOTAL);
    localparam int XW      = clog2(BOARD_W);
    localparam int YW      = clog2(BOARD_H);
    localparam int L       = RAM_LAT + 2;
    localparam int TILE    = 1 << TILE_LOG2;

    // Board and border rectangles as half-open [lo, hi) ranges
    localparam logic [HW-1:0] BX_LO = HW'(BOARD_X0);
    localparam logic [HW-1:0] BX_HI = HW'(BOARD_X0 + (BOARD_W << TILE_LOG2));
    localparam logic [VW-1:0] BY_LO = VW'(BOARD_Y0);
    localparam logic [VW-1:0] BY_HI = VW'(BOARD_Y0 + (BOARD_H << TILE_LOG2));
    localparam logic [HW-1:0] OX_LO = HW'(BOARD_X0 - BORDER);
    localparam logic [HW-1:0] OX_HI = HW'(BOARD_X0 + (BOARD_W << TILE_LOG2) + BORDER);
    localparam logic [VW-1:0] OY_LO = VW'(BOARD_Y0 - BORDER);
    localparam logic [VW-1:0] OY_HI = VW'(BOARD_Y0 + (BOARD_H << TILE_LOG2) + BORDER);

    // Dot occupies tile-local coordinates [2, TILE-2] inclusive on both axes
    localparam logic [TILE_LOG2-1:0] DOT_LO = TILE_LOG2'(2);
    localparam logic [TILE_LOG2-1:0] DOT_HI = TILE_LOG2'(TILE - 2);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hs_raw;
    logic          vs_raw;
    logic          visible_raw;

    vga_tile_renderer_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (HS_POL),   .VS_POL (VS_POL),
        .HW       (HW),       .VW     (VW)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .visible     (visible_raw),
        .frame_start (frame_start)
    );

    logic [HW-1:0] x_off;
    logic [VW-1:0] y_off;
    logic          in_board;
    meta_t         meta_nxt;

    // Stage-0 region decode from the raw counters
    always_comb begin
        x_off    = h_cnt - BX_LO;
        y_off    = v_cnt - BY_LO;
        in_board = (h_cnt >= BX_LO) && (h_cnt < BX_HI) &&
                   (v_cnt >= BY_LO) && (v_cnt < BY_HI);
        meta_nxt.visible = visible_raw;
        meta_nxt.border  = (h_cnt >= OX_LO) && (h_cnt < OX_HI) &&
                           (v_cnt >= OY_LO) && (v_cnt < OY_HI) && !in_board;
        meta_nxt.dot     = in_board &&
                           (x_off[TILE_LOG2-1:0] >= DOT_LO) && (x_off[TILE_LOG2-1:0] <= DOT_HI) &&
                           (y_off[TILE_LOG2-1:0] >= DOT_LO) && (y_off[TILE_LOG2-1:0] <= DOT_HI);
    end

    // Stage 1: cell address, held outside the board so the RAM sees no spurious reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_x <= '0;
            ram_y <= '0;
        end else if (in_board) begin
            ram_x <= XW'(x_off >> TILE_LOG2);
            ram_y <= YW'(y_off >> TILE_LOG2);
        end
    end

    // Region flags delayed so that meta_pipe[RAM_LAT] lines up with ram_out
    meta_t meta_pipe [RAM_LAT+1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RAM_LAT; i++) meta_pipe[i] <= '0;
        end else begin
            meta_pipe[0] <= meta_nxt;
            for (int i = 1; i <= RAM_LAT; i++) meta_pipe[i] <= meta_pipe[i-1];
        end
    end

    // Sync levels delayed by the full pipeline depth to stay aligned with rgb
    logic [L-1:0] hs_pipe;
    logic [L-1:0] vs_pipe;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe <= {L{~HS_POL}};
            vs_pipe <= {L{~VS_POL}};
        end else begin
            hs_pipe <= {hs_pipe[L-2:0], hs_raw};
            vs_pipe <= {vs_pipe[L-2:0], vs_raw};
        end
    end
    assign hs = hs_pipe[L-1];
    assign vs = vs_pipe[L-1];

    logic                  go_lat;
    logic [FLASH_LOG2:0]   flash_cnt;

    // Game-over latch and flash counter move only at frame_start, so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_lat    <= 1'b0;
            flash_cnt <= '0;
        end else if (frame_start) begin
            go_lat <= game_over;
            if (!game_over)  flash_cnt <= '0;
            else if (go_lat) flash_cnt <= flash_cnt + 1'b1;
        end
    end

    logic [7:0] rgb_nxt;
    logic [7:0] rgb;

    // Colour priority: blanking, border (flashing), full cell, occupied cell, background
    always_comb begin
        rgb_nxt = RGB_BG;
        if (!meta_pipe[RAM_LAT].visible)
            rgb_nxt = RGB_OFF;
        else if (meta_pipe[RAM_LAT].border)
            rgb_nxt = (go_lat && flash_cnt[FLASH_LOG2]) ? RGB_BORDER_GO : RGB_BORDER;
        else if (meta_pipe[RAM_LAT].dot && (&ram_out))
            rgb_nxt = RGB_CELL_FULL;
        else if (meta_pipe[RAM_LAT].dot && (|ram_out))
            rgb_nxt = RGB_CELL;
    end

    // Stage L: registered pixel colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= RGB_OFF;
        else        rgb <= rgb_nxt;
    end
    assign {r, g, b} = rgb;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer in a reduced video mode (80x47 raster, 8-pixel tiles).
// Two instances: RAM_LAT=1 (main) and RAM_LAT=3 (latency check), each with its own cell RAM model.
// Expected values are hand-derived from the mode parameters below.
module tb_vga_tile_renderer;

    localparam int HT = 80;           // 64 + 4 + 8 + 4
    localparam int VT = 47;           // 40 + 2 + 2 + 3
    localparam int N  = HT * VT;      // 3760 clocks per frame
    localparam int L1 = 3;            // RAM_LAT=1 pipeline depth
    localparam int L3 = 5;            // RAM_LAT=3 pipeline depth

    localparam logic [7:0] C_OFF  = 8'h00;
    localparam logic [7:0] C_BRD  = 8'b01001010;
    localparam logic [7:0] C_RED  = 8'b11100000;
    localparam logic [7:0] C_FULL = 8'b10010000;
    localparam logic [7:0] C_CELL = 8'hFF;
    localparam logic [7:0] C_BG   = 8'b00100101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic game_over = 1'b0;

    logic       hs1, vs1, fs1, hs3, vs3, fs3;
    logic [2:0] r1, g1, r3, g3;
    logic [1:0] b1, b3;
    logic [1:0] ram_x1, ram_y1, ram_x3, ram_y3;
    logic [3:0] ram_out1 = '0;
    logic [3:0] ram_out3 = '0;
    logic [3:0] d3a = '0;
    logic [3:0] d3b = '0;
    logic [7:0] rgb1, rgb3;

    int checks = 0;
    int errors = 0;
    int tick   = 0;

    assign rgb1 = {r1, g1, b1};
    assign rgb3 = {r3, g3, b3};

    always #5 clk = ~clk;

    vga_tile_renderer #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b1), .TILE_LOG2(3),
        .BOARD_W(4), .BOARD_H(3), .BOARD_X0(8), .BOARD_Y0(8), .BORDER(4),
        .CELL_W(4), .RAM_LAT(1), .FLASH_LOG2(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .hs(hs1), .vs(vs1), .r(r1), .g(g1), .b(b1),
        .ram_x(ram_x1), .ram_y(ram_y1), .ram_out(ram_out1),
        .game_over(game_over), .frame_start(fs1)
    );

    vga_tile_renderer #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b1), .TILE_LOG2(3),
        .BOARD_W(4), .BOARD_H(3), .BOARD_X0(8), .BOARD_Y0(8), .BORDER(4),
        .CELL_W(4), .RAM_LAT(3), .FLASH_LOG2(1)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .hs(hs3), .vs(vs3), .r(r3), .g(g3), .b(b3),
        .ram_x(ram_x3), .ram_y(ram_y3), .ram_out(ram_out3),
        .game_over(game_over), .frame_start(fs3)
    );

    // Board contents: (0,0)=F full, (2,1)=5, (3,2)=3, everything else empty
    function automatic logic [3:0] cell_of(input logic [1:0] cx, input logic [1:0] cy);
        case ({cx, cy})
            4'b00_00: return 4'hF;
            4'b10_01: return 4'h5;
            4'b11_10: return 4'h3;
            default:  return 4'h0;
        endcase
    endfunction

    // Cell RAM with one clock of read latency
    always @(posedge clk) ram_out1 <= cell_of(ram_x1, ram_y1);

    // Cell RAM with three clocks of read latency
    always @(posedge clk) begin
        d3a      <= cell_of(ram_x3, ram_y3);
        d3b      <= d3a;
        ram_out3 <= d3b;
    end

    // Clocks since reset release == linear raster position of the DUT counters
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick <= 0;
        else        tick <= tick + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_pos(input int target);
        bit hit;
        int t;
        hit = 1'b0;
        t   = target % N;
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge clk);
            #1;
            if ((tick % N) == t) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL wait_pos: position never reached, required %0d", t);
        end
    endtask

    task automatic pix1(input string tag, input int x, input int y, input logic [7:0] exp_v);
        wait_pos(y * HT + x + L1);
        chk(tag, 32'(rgb1), 32'(exp_v));
    endtask

    task automatic pix3(input string tag, input int x, input int y, input logic [7:0] exp_v);
        wait_pos(y * HT + x + L3);
        chk(tag, 32'(rgb3), 32'(exp_v));
    endtask

    initial begin
        int lows;
        int cnt;
        logic [7:0] flash_exp [4];
        flash_exp = '{C_BRD, C_BRD, C_RED, C_RED};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hs", 32'(hs1), 32'd1);
        chk("rst_vs", 32'(vs1), 32'd0);
        chk("rst_rgb", 32'(rgb1), 32'd0);
        chk("rst_ram_xy", 32'({ram_x1, ram_y1}), 32'd0);
        chk("rst_frame_start", 32'(fs1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Horizontal sync window [68,76) on line 0
        pix1("hs_before_sync", 67, 0, C_OFF);
        chk("hs_at_67", 32'(hs1), 32'd1);
        wait_pos(68 + L1);
        chk("hs_at_68", 32'(hs1), 32'd0);
        wait_pos(75 + L1);
        chk("hs_at_75", 32'(hs1), 32'd0);
        wait_pos(76 + L1);
        chk("hs_at_76", 32'(hs1), 32'd1);

        // Sync low for exactly 8 clocks of an 80-clock line
        wait_pos(2 * HT + L1);
        lows = 0;
        for (int i = 0; i < HT; i++) begin
            if (hs1 == 1'b0) lows++;
            @(posedge clk);
            #1;
        end
        chk("hs_low_per_line", 32'(lows), 32'd8);

        // Pixel colours across the board, border and blanking
        pix1("border_corner", 5, 5, C_BRD);
        pix1("gap_before_full", 9, 10, C_BG);
        pix1("full_cell_lat1", 10, 10, C_FULL);
        pix3("gap_before_full_lat3", 9, 10, C_BG);
        pix3("full_cell_lat3", 10, 10, C_FULL);
        pix1("hblank", 64, 10, C_OFF);
        pix1("empty_cell_dot", 18, 18, C_BG);
        pix1("left_of_border", 3, 20, C_BG);
        pix1("border_right", 43, 20, C_BRD);
        pix1("right_of_border", 44, 20, C_BG);
        wait_pos(26 * HT + 34 + 1);
        chk("ram_addr_3_2", 32'({ram_x1, ram_y1}), 32'({2'd3, 2'd2}));
        pix1("cell3_dot", 34, 26, C_CELL);
        wait_pos(26 * HT + 45 + 1);
        chk("ram_addr_hold", 32'({ram_x1, ram_y1}), 32'({2'd3, 2'd2}));
        pix1("cell3_dot_edge", 38, 30, C_CELL);
        pix1("cell3_gap", 39, 30, C_BG);
        pix3("cell3_dot_edge_lat3", 38, 30, C_CELL);
        pix1("border_bottom", 20, 35, C_BRD);
        pix1("below_border", 20, 36, C_BG);
        pix1("vblank", 10, 40, C_OFF);

        // Vertical sync on lines 42 and 43 only
        wait_pos(41 * HT + L1);
        chk("vs_line41", 32'(vs1), 32'd0);
        wait_pos(42 * HT + L1);
        chk("vs_line42", 32'(vs1), 32'd1);
        wait_pos(43 * HT + L1);
        chk("vs_line43", 32'(vs1), 32'd1);
        wait_pos(44 * HT + L1);
        chk("vs_line44", 32'(vs1), 32'd0);

        // frame_start at 0,0 and its period
        wait_pos(0);
        chk("frame_start_at_origin", 32'(fs1), 32'd1);
        cnt = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (fs1) break;
        end
        chk("frame_start_period", 32'(cnt), 32'(N));

        // Game over raised mid-frame: no change until next frame, then 2 base / 2 red
        wait_pos(20 * HT + 30);
        game_over = 1'b1;
        pix1("go_same_frame", 20, 35, C_BRD);
        for (int k = 0; k < 4; k++) begin
            pix1("go_flash", 5, 5, flash_exp[k]);
        end
        game_over = 1'b0;
        pix1("go_released", 5, 5, C_BRD);
        game_over = 1'b1;
        pix1("go_restart_cnt0", 5, 5, C_BRD);
        pix1("go_dot_unaffected", 10, 10, C_FULL);
        pix1("go_restart_cnt1", 5, 5, C_BRD);
        pix1("go_restart_cnt2", 5, 5, C_RED);
        game_over = 1'b0;

        // Asynchronous reset mid-frame, then a full frame to the next frame_start
        pix1("pre_reset_cell5", 27, 20, C_CELL);
        rst_n = 1'b0;
        #1;
        chk("arst_hs", 32'(hs1), 32'd1);
        chk("arst_vs", 32'(vs1), 32'd0);
        chk("arst_rgb", 32'(rgb1), 32'd0);
        chk("arst_ram_xy", 32'({ram_x1, ram_y1}), 32'd0);
        chk("arst_frame_start", 32'(fs1), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (fs1) break;
        end
        chk("frame_start_after_release", 32'(cnt), 32'(N));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
